// File: rtl/sort_engine.sv
// sort_engine: N-element odd-even transposition sorter, one compare-exchange
// phase per clock, valid/ready on both sides, signed/unsigned and
// ascending/descending modes, optional early exit and a swap counter.
module sort_engine #(
    parameter  int unsigned WIDTH      = 32,
    parameter  int unsigned N          = 8,
    parameter  int unsigned EARLY_EXIT = 1,
    localparam int unsigned CW         = $clog2(N * N / 2 + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic                 signed_mode,
    input  logic                 descending,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [CW-1:0]        swap_count
);

    localparam int unsigned PW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SORT,
        ST_DONE
    } state_t;

    state_t                    state_q;
    logic [N-1:0][WIDTH-1:0]   vec_q;
    logic [N-1:0][WIDTH-1:0]   vec_d;
    logic                      signed_q;
    logic                      desc_q;
    logic [PW-1:0]             phase_q;
    logic                      prev_zero_q;
    logic [CW-1:0]             swaps_d;
    logic [CW-1:0]             swap_count_q;
    logic                      out_valid_q;
    logic [N*WIDTH-1:0]        out_data_q;

    logic                      accept;
    logic                      phase_last;
    logic                      phase_zero;
    logic                      finish;

    // Strict greater-than under the latched signedness.
    function automatic logic gt(input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b,
                                input logic             sgn);
        if (sgn) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // One compare-exchange phase over the pairs selected by the phase parity.
    always_comb begin
        vec_d   = vec_q;
        swaps_d = '0;
        for (int i = 0; i < int'(N) - 1; i++) begin
            if (1'(i) == phase_q[0]) begin
                if (desc_q ? gt(vec_q[i+1], vec_q[i], signed_q)
                           : gt(vec_q[i], vec_q[i+1], signed_q)) begin
                    vec_d[i]   = vec_q[i+1];
                    vec_d[i+1] = vec_q[i];
                    swaps_d    = swaps_d + CW'(1);
                end
            end
        end
    end

    // Handshake and termination decisions.
    always_comb begin
        in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        accept     = in_valid && in_ready;
        phase_last = (phase_q == PW'(N - 1));
        phase_zero = (swaps_d == '0);
        finish     = phase_last ||
                     ((EARLY_EXIT != 0) && (phase_q != '0) && prev_zero_q && phase_zero);
    end

    // Sequencer: accept, step phases, present the result until it is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            signed_q     <= 1'b0;
            desc_q       <= 1'b0;
            phase_q      <= '0;
            prev_zero_q  <= 1'b0;
            swap_count_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else if (accept) begin
            // Covers IDLE and the back-to-back case out of DONE.
            state_q      <= ST_SORT;
            vec_q        <= in_data;
            signed_q     <= signed_mode;
            desc_q       <= descending;
            phase_q      <= '0;
            prev_zero_q  <= 1'b0;
            swap_count_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_SORT: begin
                    vec_q        <= vec_d;
                    swap_count_q <= swap_count_q + swaps_d;
                    prev_zero_q  <= phase_zero;
                    phase_q      <= phase_q + PW'(1);
                    if (finish) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= vec_d;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign swap_count = swap_count_q;

endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: scoreboard bench for sort_engine. Instance A: N=4 fixed
// phases, B: N=4 early exit, C: N=8 early exit with random vectors.
module tb_sort_engine;

    logic clk;
    logic rst;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    logic        a_in_valid, a_in_ready, a_sm, a_desc, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [3:0]  a_swaps;
    logic        b_in_valid, b_in_ready, b_sm, b_desc, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [3:0]  b_swaps;
    logic        c_in_valid, c_in_ready, c_sm, c_desc, c_out_valid, c_out_ready;
    logic [63:0] c_in_data, c_out_data;
    logic [5:0]  c_swaps;

    typedef struct {
        logic [63:0] data;
        int          swaps;
        int          lat;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   acc_a = 0, acc_b = 0, acc_c = 0;
    int   lat_a = 0, lat_b = 0, lat_c = 0;
    bit   pv_a = 0, pv_b = 0, pv_c = 0;
    logic [7:0] pool [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

    sort_engine #(.WIDTH(8), .N(4), .EARLY_EXIT(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .signed_mode(a_sm), .descending(a_desc),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .swap_count(a_swaps));

    sort_engine #(.WIDTH(8), .N(4), .EARLY_EXIT(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .signed_mode(b_sm), .descending(b_desc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .swap_count(b_swaps));

    sort_engine #(.WIDTH(8), .N(8), .EARLY_EXIT(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .signed_mode(c_sm), .descending(c_desc),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .swap_count(c_swaps));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=output_present required=no_output", name);
    endfunction

    function automatic logic [63:0] pack4(input logic [7:0] e0, input logic [7:0] e1,
                                          input logic [7:0] e2, input logic [7:0] e3);
        return {32'h0, e3, e2, e1, e0};
    endfunction

    function automatic bit gt8(input logic [7:0] a, input logic [7:0] b, input bit sm);
        return sm ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    // True when a must be placed after b in the requested order.
    function automatic bit after8(input logic [7:0] a, input logic [7:0] b, input bit sm, input bit desc);
        return desc ? gt8(b, a, sm) : gt8(a, b, sm);
    endfunction

    // Reference: stable insertion sort; exchange count equals inversion count.
    function automatic void model(input logic [63:0] din, input bit sm, input bit desc,
                                  output logic [63:0] dout, output int sw);
        logic [7:0] v [8];
        logic [7:0] key;
        int j;
        for (int i = 0; i < 8; i++) v[i] = din[i*8 +: 8];
        sw = 0;
        for (int i = 0; i < 8; i++)
            for (int k = i + 1; k < 8; k++)
                if (after8(v[i], v[k], sm, desc)) sw++;
        for (int i = 1; i < 8; i++) begin
            key = v[i];
            j = i - 1;
            while (j >= 0 && after8(v[j], key, sm, desc)) begin
                v[j+1] = v[j];
                j--;
            end
            v[j+1] = key;
        end
        for (int i = 0; i < 8; i++) dout[i*8 +: 8] = v[i];
    endfunction

    // Monitor A
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst) pv_a = 1'b0;
        else begin
            if (a_out_valid && !pv_a) lat_a = cyc - acc_a;
            pv_a = a_out_valid;
            if (a_out_valid && a_out_ready) begin
                if (q_a.size() == 0) unexpected("a_unexpected_out");
                else begin
                    e = q_a.pop_front();
                    chk("a_data", {32'h0, a_out_data}, e.data);
                    chk("a_swaps", 64'(a_swaps), 64'(e.swaps));
                    if (e.lat >= 0) chk("a_latency", 64'(lat_a), 64'(e.lat));
                end
            end
            if (a_in_valid && a_in_ready) acc_a = cyc + 1;
        end
    end

    // Monitor B
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst) pv_b = 1'b0;
        else begin
            if (b_out_valid && !pv_b) lat_b = cyc - acc_b;
            pv_b = b_out_valid;
            if (b_out_valid && b_out_ready) begin
                if (q_b.size() == 0) unexpected("b_unexpected_out");
                else begin
                    e = q_b.pop_front();
                    chk("b_data", {32'h0, b_out_data}, e.data);
                    chk("b_swaps", 64'(b_swaps), 64'(e.swaps));
                    if (e.lat >= 0) chk("b_latency", 64'(lat_b), 64'(e.lat));
                end
            end
            if (b_in_valid && b_in_ready) acc_b = cyc + 1;
        end
    end

    // Monitor C
    always @(negedge clk) begin : mon_c
        exp_t e;
        if (!rst) pv_c = 1'b0;
        else begin
            if (c_out_valid && !pv_c) lat_c = cyc - acc_c;
            pv_c = c_out_valid;
            if (c_out_valid && c_out_ready) begin
                if (q_c.size() == 0) unexpected("c_unexpected_out");
                else begin
                    e = q_c.pop_front();
                    chk("c_data", c_out_data, e.data);
                    chk("c_swaps", 64'(c_swaps), 64'(e.swaps));
                    if (e.lat >= 0) chk("c_latency", 64'(lat_c), 64'(e.lat));
                    else chk("c_latency_in_range", 64'(lat_c >= 2 && lat_c <= 8), 64'(1));
                end
            end
            if (c_in_valid && c_in_ready) acc_c = cyc + 1;
        end
    end

    function automatic int qsize(input int sel);
        case (sel)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    function automatic logic ready(input int sel);
        case (sel)
            0:       return a_in_ready;
            1:       return b_in_ready;
            default: return c_in_ready;
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [63:0] d, input bit sm, input bit desc);
        case (sel)
            0:       begin a_in_valid = v; a_in_data = d[31:0]; a_sm = sm; a_desc = desc; end
            1:       begin b_in_valid = v; b_in_data = d[31:0]; b_sm = sm; b_desc = desc; end
            default: begin c_in_valid = v; c_in_data = d;       c_sm = sm; c_desc = desc; end
        endcase
    endtask

    // Issue one vector; modes are flipped after accept to show they are not re-sampled.
    task automatic send(input int sel, input logic [63:0] d, input bit sm, input bit desc,
                        input logic [63:0] ed, input int es, input int el, input bit push);
        exp_t e;
        int   n;
        bit   got;
        e.data = ed; e.swaps = es; e.lat = el;
        if (push) begin
            case (sel)
                0:       q_a.push_back(e);
                1:       q_b.push_back(e);
                default: q_c.push_back(e);
            endcase
        end
        drive(sel, 1'b1, d, sm, desc);
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = ready(sel);
            n++;
        end
        if (got) @(posedge clk);
        #1;
        drive(sel, 1'b0, d, ~sm, ~desc);
        if (!got) begin
            checks++; failures++;
            $display("FAIL accept_timeout sel=%0d actual=no_accept required=accept", sel);
            if (push) begin
                case (sel)
                    0:       void'(q_a.pop_back());
                    1:       void'(q_b.pop_back());
                    default: void'(q_c.pop_back());
                endcase
            end
        end
    endtask

    task automatic wait_drain(input int sel);
        int n = 0;
        while (qsize(sel) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (qsize(sel) != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout sel=%0d actual=%0d_pending required=0", sel, qsize(sel));
            case (sel)
                0:       q_a.delete();
                1:       q_b.delete();
                default: q_c.delete();
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d, ed;
        int          es, n;
        bit          sm, desc;

        rst = 1'b0;
        drive(0, 1'b0, 64'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 64'h0, 1'b0, 1'b0);
        drive(2, 1'b0, 64'h0, 1'b0, 1'b0);
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(a_out_valid), 64'(0));
        chk("reset_out_data", {32'h0, a_out_data}, 64'h0);
        chk("reset_swap_count", 64'(a_swaps), 64'(0));
        chk("reset_in_ready", 64'(a_in_ready), 64'(1));
        chk("reset_c_out_data", c_out_data, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Signed ascending, then the same bits unsigned.
        send(0, pack4(8'd5, 8'hFD, 8'd60, 8'd0), 1'b1, 1'b0, pack4(8'hFD, 8'd0, 8'd5, 8'd60), 3, 4, 1'b1);
        wait_drain(0);
        send(0, pack4(8'd5, 8'hFD, 8'd60, 8'd0), 1'b0, 1'b0, pack4(8'd0, 8'd5, 8'h3C, 8'hFD), 4, 4, 1'b1);
        wait_drain(0);

        // Early exit: sorted, fully reversed (runs all phases), one swap then clean.
        send(1, pack4(8'd1, 8'd2, 8'd3, 8'd4), 1'b0, 1'b0, pack4(8'd1, 8'd2, 8'd3, 8'd4), 0, 2, 1'b1);
        wait_drain(1);
        send(1, pack4(8'd4, 8'd3, 8'd2, 8'd1), 1'b0, 1'b0, pack4(8'd1, 8'd2, 8'd3, 8'd4), 6, 4, 1'b1);
        wait_drain(1);
        send(1, pack4(8'd2, 8'd1, 8'd3, 8'd4), 1'b0, 1'b0, pack4(8'd1, 8'd2, 8'd3, 8'd4), 1, 3, 1'b1);
        wait_drain(1);

        // Descending, fixed phases; then ties stay stable.
        send(0, pack4(8'd1, 8'd2, 8'd3, 8'd4), 1'b0, 1'b1, pack4(8'd4, 8'd3, 8'd2, 8'd1), 6, 4, 1'b1);
        wait_drain(0);
        send(0, pack4(8'd7, 8'd7, 8'hFF, 8'd7), 1'b1, 1'b0, pack4(8'hFF, 8'd7, 8'd7, 8'd7), 2, 4, 1'b1);
        wait_drain(0);

        // Backpressure, then simultaneous out/in handshakes.
        a_out_ready = 1'b0;
        send(0, pack4(8'd9, 8'd8, 8'd7, 8'd6), 1'b0, 1'b0, pack4(8'd6, 8'd7, 8'd8, 8'd9), 6, 4, 1'b1);
        n = 0;
        while (!a_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_rise", 64'(a_out_valid), 64'(1));
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held", 64'(a_out_valid), 64'(1));
            chk("bp_data_held", {32'h0, a_out_data}, pack4(8'd6, 8'd7, 8'd8, 8'd9));
            chk("bp_in_ready_low", 64'(a_in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        q_a.push_back('{pack4(8'h7F, 8'd2, 8'd1, 8'h80), 5, 4});
        drive(0, 1'b1, pack4(8'h80, 8'd1, 8'h7F, 8'd2), 1'b1, 1'b1);
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_with_out_ready", 64'(a_in_ready), 64'(1));
        @(posedge clk);
        #1;
        drive(0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("bp_out_valid_drop", 64'(a_out_valid), 64'(0));
        wait_drain(0);

        // Asynchronous reset mid-sort, then a clean vector.
        send(0, pack4(8'd3, 8'd1, 8'd2, 8'd0), 1'b0, 1'b0, 64'h0, 0, 0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 64'(a_out_valid), 64'(0));
        chk("abort_out_data", {32'h0, a_out_data}, 64'h0);
        chk("abort_in_ready", 64'(a_in_ready), 64'(1));
        chk("abort_swap_count", 64'(a_swaps), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(0, pack4(8'h10, 8'h20, 8'h05, 8'h30), 1'b0, 1'b0, pack4(8'h05, 8'h10, 8'h20, 8'h30), 2, 4, 1'b1);
        wait_drain(0);

        // Random N=8 vectors against the reference model, both modes.
        for (int k = 0; k < 1000; k++) begin
            for (int b = 0; b < 8; b++)
                d[b*8 +: 8] = (k % 3 == 0) ? pool[$urandom_range(0, 4)] : 8'($urandom);
            sm   = 1'($urandom_range(0, 1));
            desc = 1'($urandom_range(0, 1));
            model(d, sm, desc, ed, es);
            send(2, d, sm, desc, ed, es, -1, 1'b1);
        end
        wait_drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
